// File: rtl/pipes.sv
// Shared types for the pipeline stall/flush controller.
// Fetch FSM states and PC-source selects.
package pipes;

  typedef enum logic [1:0] {
    F_RUN  = 2'd0,
    F_BUF  = 2'd1,
    F_HOLD = 2'd2
  } fstate_t;

  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_PENDING  = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pipe_ctrl_fetch_fsm.sv
// Fetch FSM: keeps fetch returns and redirect targets
// alive while the bus or the pipeline is busy.
module fetch_fsm
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ok,
  input  logic [31:0] data,
  input  logic        redirect,
  input  logic [63:0] target,
  input  logic        stall_fd,
  output fstate_t     state,
  output logic [63:0] pc_pending,
  output logic        ireq_valid,
  output logic [31:0] instr_out
);

  fstate_t     state_d;
  logic [31:0] ibuf, ibuf_d;
  logic [63:0] pend_d;

  // State, buffered instruction and pending target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= F_RUN;
      ibuf       <= 32'd0;
      pc_pending <= 64'd0;
    end else begin
      state      <= state_d;
      ibuf       <= ibuf_d;
      pc_pending <= pend_d;
    end
  end

  // Next state; a redirect either applies now or parks in F_HOLD
  always_comb begin
    state_d = state;
    ibuf_d  = ibuf;
    pend_d  = pc_pending;
    unique case (state)
      F_RUN: begin
        if (redirect) begin
          if (!data_ok) begin
            pend_d  = target;
            state_d = F_HOLD;
          end
        end else if (data_ok && stall_fd) begin
          ibuf_d  = data;
          state_d = F_BUF;
        end
      end
      F_BUF: begin
        if (redirect || !stall_fd)
          state_d = F_RUN;
      end
      F_HOLD: begin
        if (data_ok)
          state_d = F_RUN;
        else if (redirect)
          pend_d = target;
      end
      default: state_d = F_RUN;
    endcase
  end

  assign ireq_valid = (state != F_BUF);
  assign instr_out  = (state == F_BUF) ? ibuf : data;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller: per-stage enables, bubbles,
// PC update select and instruction-bus request.
module pipe_ctrl
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic        dresp_data_ok,
  input  logic        ex_redirect,
  input  logic [63:0] ex_target,
  input  logic        ex_memread,
  input  logic [4:0]  ex_dst,
  input  logic [4:0]  id_ra1,
  input  logic [4:0]  id_ra2,
  input  logic        id_use1,
  input  logic        id_use2,
  output logic        ireq_valid,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [63:0] pc_pending,
  output logic [31:0] instr_out,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        bub_fd,
  output logic        bub_de,
  output logic        bub_em,
  output logic        bub_mw
);

  fstate_t state;
  logic    mem_stall;
  logic    load_use;
  logic    redirect;
  logic    fetch_ok;
  logic    hold_done;

  assign mem_stall = dreq_valid & ~dresp_data_ok;
  assign load_use  = ex_memread & (ex_dst != 5'd0) &
                     ((id_use1 & (id_ra1 == ex_dst)) |
                      (id_use2 & (id_ra2 == ex_dst)));
  // EX is frozen during a mem stall and re-presents the redirect
  assign redirect  = ex_redirect & ~mem_stall;
  assign fetch_ok  = ((state == F_RUN) & iresp_data_ok) |
                     (state == F_BUF);
  assign hold_done = (state == F_HOLD) & iresp_data_ok;

  fetch_fsm u_fetch (
    .clk        (clk),
    .reset      (reset),
    .data_ok    (iresp_data_ok),
    .data       (iresp_data),
    .redirect   (redirect),
    .target     (ex_target),
    .stall_fd   (mem_stall | load_use),
    .state      (state),
    .pc_pending (pc_pending),
    .ireq_valid (ireq_valid),
    .instr_out  (instr_out)
  );

  // Stage enables, bubbles and PC update in priority order
  always_comb begin
    en_fd  = 1'b1;
    en_de  = 1'b1;
    en_em  = 1'b1;
    en_mw  = 1'b1;
    bub_fd = 1'b0;
    bub_de = 1'b0;
    bub_em = 1'b0;
    bub_mw = 1'b0;
    pc_we  = 1'b0;
    pc_sel = PC_SEQ;
    if (!reset) begin
      if (state == F_HOLD)
        bub_fd = 1'b1;
      if (mem_stall) begin
        en_fd  = 1'b0;
        en_de  = 1'b0;
        en_em  = 1'b0;
        bub_mw = 1'b1;
        if (hold_done) begin
          pc_we  = 1'b1;
          pc_sel = PC_PENDING;
        end
      end else if (ex_redirect) begin
        bub_fd = 1'b1;
        bub_de = 1'b1;
        if (fetch_ok || hold_done) begin
          pc_we  = 1'b1;
          pc_sel = PC_REDIRECT;
        end
      end else if (load_use) begin
        en_fd  = 1'b0;
        bub_de = 1'b1;
        if (hold_done) begin
          pc_we  = 1'b1;
          pc_sel = PC_PENDING;
        end
      end else begin
        unique case (state)
          F_RUN: begin
            if (iresp_data_ok) pc_we  = 1'b1;
            else               bub_fd = 1'b1;
          end
          F_BUF: pc_we = 1'b1;
          F_HOLD: begin
            if (iresp_data_ok) begin
              pc_we  = 1'b1;
              pc_sel = PC_PENDING;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then random
// traffic, all checked against a flag-based reference model.
module tb_pipe_ctrl;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic        dresp_data_ok;
  logic        ex_redirect;
  logic [63:0] ex_target;
  logic        ex_memread;
  logic [4:0]  ex_dst;
  logic [4:0]  id_ra1;
  logic [4:0]  id_ra2;
  logic        id_use1;
  logic        id_use2;
  logic        ireq_valid;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [63:0] pc_pending;
  logic [31:0] instr_out;
  logic        en_fd, en_de, en_em, en_mw;
  logic        bub_fd, bub_de, bub_em, bub_mw;

  int passed = 0;
  int total  = 0;
  int pend_sel_seen = 0;

  // reference model: two flags plus stored values
  bit          m_buffered = 0;
  bit          m_holding  = 0;
  logic [63:0] m_pend     = 64'd0;
  logic [31:0] m_bufd     = 32'd0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dresp_data_ok (dresp_data_ok),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .ex_memread    (ex_memread),
    .ex_dst        (ex_dst),
    .id_ra1        (id_ra1),
    .id_ra2        (id_ra2),
    .id_use1       (id_use1),
    .id_use2       (id_use2),
    .ireq_valid    (ireq_valid),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .pc_pending    (pc_pending),
    .instr_out     (instr_out),
    .en_fd         (en_fd),
    .en_de         (en_de),
    .en_em         (en_em),
    .en_mw         (en_mw),
    .bub_fd        (bub_fd),
    .bub_de        (bub_de),
    .bub_em        (bub_em),
    .bub_mw        (bub_mw)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0t got=%h want=%h",
                tag, $time, obs, exp);
  endtask

  task automatic idle();
    reset         = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = $urandom;
    dreq_valid    = 1'b0;
    dresp_data_ok = 1'b0;
    ex_redirect   = 1'b0;
    ex_target     = {$urandom, $urandom};
    ex_memread    = 1'b0;
    ex_dst        = 5'd0;
    id_ra1        = 5'd0;
    id_ra2        = 5'd0;
    id_use1       = 1'b0;
    id_use2       = 1'b0;
  endtask

  // Check one cycle against the model, then advance it
  task automatic cyc(input bit full = 1'b1);
    bit ms, lu, rd, luw, have, hdone, stall;
    bit e_we;
    logic [1:0] e_sel;
    #1;
    ms    = dreq_valid & ~dresp_data_ok;
    lu    = ex_memread && ex_dst != 0 &&
            ((id_use1 && id_ra1 == ex_dst) ||
             (id_use2 && id_ra2 == ex_dst));
    rd    = ex_redirect & ~ms;
    luw   = lu & ~ms & ~ex_redirect;
    have  = m_buffered | (~m_holding & iresp_data_ok);
    hdone = m_holding & iresp_data_ok;
    stall = ms | lu;
    e_we  = 1'b0;
    e_sel = PC_SEQ;
    if (hdone && !rd) begin
      e_we = 1'b1; e_sel = PC_PENDING;
    end else if (rd && (have || hdone)) begin
      e_we = 1'b1; e_sel = PC_REDIRECT;
    end else if (!ms && !luw && !rd && have) begin
      e_we = 1'b1;
    end
    if (pc_we && pc_sel == PC_PENDING) pend_sel_seen++;
    if (full) begin
      chk("ireq_valid", ireq_valid, !m_buffered);
      chk("instr_out", instr_out,
          m_buffered ? m_bufd : iresp_data);
      chk("pc_pending", pc_pending, m_pend);
    end
    if (reset) begin
      chk("rst_en", {en_fd, en_de, en_em, en_mw}, 4'hf);
      chk("rst_bub", {bub_fd, bub_de, bub_em, bub_mw}, 4'h0);
      chk("rst_pc_we", pc_we, 1'b0);
    end else begin
      chk("en", {en_fd, en_de, en_em, en_mw},
          {~(ms | luw), ~ms, ~ms, 1'b1});
      chk("bub", {bub_fd, bub_de, bub_em, bub_mw},
          {rd | m_holding |
             (~ms & ~luw & ~m_buffered & ~m_holding &
              ~iresp_data_ok),
           rd | luw, 1'b0, ms});
      chk("pc_we", pc_we, e_we);
      chk("pc_sel", pc_sel, e_sel);
    end
    if (reset) begin
      m_buffered = 0; m_holding = 0;
      m_pend = 64'd0; m_bufd = 32'd0;
    end else if (rd) begin
      if (have || hdone) begin
        m_buffered = 0; m_holding = 0;
      end else begin
        m_pend = ex_target; m_holding = 1;
      end
    end else if (hdone) begin
      m_holding = 0;
    end else if (m_buffered && !stall) begin
      m_buffered = 0;
    end else if (!m_buffered && !m_holding &&
                 iresp_data_ok && stall) begin
      m_buffered = 1; m_bufd = iresp_data;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    cyc(1'b0);
    cyc();
    idle();
    cyc();

    // fetch latency 3, no hazards
    for (int r = 0; r < 3; r++) begin
      idle(); cyc();
      idle(); cyc();
      idle(); iresp_data_ok = 1'b1; cyc();
    end

    // load-use on x5, then the same with x0
    idle(); ex_memread = 1'b1; ex_dst = 5'd5;
    id_ra1 = 5'd5; id_use1 = 1'b1; iresp_data_ok = 1'b1;
    cyc();
    idle(); cyc();
    idle(); ex_memread = 1'b1; ex_dst = 5'd0;
    id_ra1 = 5'd0; id_use1 = 1'b1; iresp_data_ok = 1'b1;
    cyc();

    // redirect two cycles before data_ok
    idle(); ex_redirect = 1'b1;
    ex_target = 64'h0000_0000_8000_0100; cyc();
    idle(); cyc();
    idle(); iresp_data_ok = 1'b1; cyc();
    idle(); cyc();

    // data_ok during a 4-cycle mem stall
    idle(); dreq_valid = 1'b1; iresp_data_ok = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); dreq_valid = 1'b1; cyc();
    end
    idle(); dreq_valid = 1'b1; dresp_data_ok = 1'b1; cyc();
    idle(); cyc();

    // redirect together with data_ok
    idle(); ex_redirect = 1'b1; iresp_data_ok = 1'b1;
    ex_target = 64'h0000_0000_8000_0200; cyc();
    idle(); cyc();

    // reset while holding a redirect
    idle(); ex_redirect = 1'b1;
    ex_target = 64'h0000_0000_8000_0300; cyc();
    idle(); reset = 1'b1; cyc();
    pend_sel_seen = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); iresp_data_ok = (i % 2) == 1; cyc();
    end
    total++;
    assert (pend_sel_seen == 0) passed++;
    else $error("FAIL pending_after_reset got=%0d want=0",
                pend_sel_seen);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      idle();
      reset         = ($urandom_range(0, 59) == 0);
      iresp_data_ok = ($urandom_range(0, 2) == 0);
      dreq_valid    = ($urandom_range(0, 3) == 0);
      dresp_data_ok = ($urandom_range(0, 1) == 0);
      ex_redirect   = ($urandom_range(0, 6) == 0);
      ex_memread    = ($urandom_range(0, 2) == 0);
      ex_dst        = 5'($urandom_range(0, 3));
      id_ra1        = 5'($urandom_range(0, 3));
      id_ra2        = 5'($urandom_range(0, 3));
      id_use1       = $urandom_range(0, 1) == 1;
      id_use2       = $urandom_range(0, 1) == 1;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage core. It decides, every cycle, whether each pipeline register advances, holds or loads a bubble, and it drives the instruction-bus request. It owns a small fetch FSM, so redirects and fetch returns that arrive while a bus access or stall is in flight are never lost. It sits beside the datapath in `core` and replaces the ad-hoc `stallpc = ireq.valid && ~iresp.data_ok` logic.

## Interface
Parameters: none. Widths come from `common` (`u1`, `u32`, `u64`, `creg_addr_t`).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `iresp_data_ok`  in  1  instruction fetch returned this cycle.
- `iresp_data`  in  32  fetched instruction.
- `dreq_valid`  in  1  MEM stage has a dbus access.
- `dresp_data_ok`  in  1  dbus access completes this cycle.
- `ex_redirect`  in  1  EX resolved a taken branch/jump.
- `ex_target`  in  64  redirect PC.
- `ex_memread`  in  1  EX holds a load.
- `ex_dst`  in  5  EX destination register.
- `id_ra1`, `id_ra2`  in  5 each  ID source registers.
- `id_use1`, `id_use2`  in  1 each  ID actually reads ra1/ra2.
- `ireq_valid`  out  1  instruction request.
- `pc_we`  out  1  PC register loads `pc_next`.
- `pc_sel`  out  2  `PC_SEQ`, `PC_REDIRECT` or `PC_PENDING`.
- `pc_pending`  out  64  latched redirect target.
- `instr_out`  out  32  instruction presented to IF/ID; this is `ibuf` when buffered, else `iresp_data`.
- `en_fd`, `en_de`, `en_em`, `en_mw`  out  1 each  pipeline-register enables.
- `bub_fd`, `bub_de`, `bub_em`, `bub_mw`  out  1 each  load bubble (cleared ctl) when enabled.

## Operation
Conditions, evaluated combinationally each cycle:
- mem_stall = `dreq_valid & ~dresp_data_ok`.
- load_use = `ex_memread & ex_dst!=0 & ((id_use1 & id_ra1==ex_dst) | (id_use2 & id_ra2==ex_dst))`.
- fetch_ok = (state==F_RUN & `iresp_data_ok`) | state==F_BUF.

Priority: mem_stall > redirect > load_use > fetch wait.
- **mem_stall:** `en_fd/de/em`=0, `en_mw`=1 with `bub_mw`=1. The redirect is ignored, because EX is frozen and re-presents it.
- **redirect** (no mem_stall): `bub_fd`=`bub_de`=1. The PC update depends on state:
  - F_RUN with `iresp_data_ok`, or F_BUF: `pc_sel`=REDIRECT and `pc_we`=1. The buffered instruction is dropped and the state goes to F_RUN.
  - F_RUN without data_ok: latch `ex_target` into `pc_pending` and go to F_HOLD. The bus address must stay stable.
- **load_use:** `en_fd`=0, `en_de`=1 with `bub_de`=1, `pc_we`=0.
- **fetch wait** (F_RUN, no data_ok): `pc_we`=0, `en_fd`=1 with `bub_fd`=1.

Fetch FSM (`fstate_t`):
- **F_RUN:** `ireq_valid`=1. On data_ok with IF/ID stalled (mem_stall or load_use), capture `iresp_data` into `ibuf` and go to F_BUF.
- **F_BUF:** `ireq_valid`=0 and `instr_out`=`ibuf`. Return to F_RUN when IF/ID accepts, and `pc_we`=1 (SEQ) that cycle.
- **F_HOLD:** `ireq_valid`=1 and `bub_fd`=1. On data_ok, discard the instruction, set `pc_sel`=PENDING and `pc_we`=1, and go to F_RUN. A new redirect in F_HOLD overwrites `pc_pending`.

## Timing
- Reset values:
  - state F_RUN, `pc_pending`=0, `ibuf`=0.
  - All `en_*`=1 and all `bub_*`=0.
  - `ireq_valid`=1 from the first cycle after reset.
  - `pc_we`=0 until the first data_ok.
- Reset asserted mid-operation drops any pending redirect or buffered instruction within one cycle.
- All outputs are combinational from inputs plus state. State, `ibuf` and `pc_pending` update on posedge `clk`.
- Redirect penalty: 2 bubbles if the fetch is complete, otherwise 2 bubbles plus the remaining fetch latency.
- Load-use inserts exactly one bubble.
- Redirect coinciding with data_ok is applied directly; F_HOLD is not entered.
- Redirect coinciding with load_use: the redirect wins and load_use is ignored (its ID instruction is flushed).

## Structure
- `fstate_t` (F_RUN/F_BUF/F_HOLD) and the `pc_sel_t` enum (PC_SEQ/PC_REDIRECT/PC_PENDING) go in `pipes`.
- Hazard detection stays inline.
- One sub-module is natural: `fetch_fsm` (state, `ibuf`, `pc_pending`, `ireq_valid`, `instr_out`), instantiated inside `pipe_ctrl`.

## Test plan
- Fetch latency 3, no hazards → `pc_we` pulses every 3rd cycle; `bub_fd`=1 on the 2 wait cycles between.
- `ex_memread`=1, `ex_dst`=5, `id_ra1`=5, `id_use1`=1 → one cycle with `en_fd`=0, `bub_de`=1; the next cycle is normal. The same with `ex_dst`=0 → no stall.
- Redirect to 0x80000100 two cycles before data_ok → F_HOLD, `pc_pending`=0x80000100; at data_ok the fetched instruction is bubbled and `pc_sel`=PENDING, `pc_we`=1.
- Data_ok during mem_stall (dresp delayed 4 cycles) → F_BUF with `ireq_valid`=0; the instruction is delivered once on release; `bub_mw`=1 on each stalled cycle.
- Redirect and data_ok in the same cycle → `pc_sel`=REDIRECT, `bub_fd`=`bub_de`=1, state stays F_RUN.
- Reset asserted in F_HOLD → next cycle is F_RUN, `pc_pending`=0, and no PENDING select ever occurs.
